fft_frame_sink: RTL and testbench
=================================

// Module: fft_frame_sink
// PURPOSE
//   AXI-stream sink at the FFT output; captures one frame of NSAMP complex bins into a capture RAM.
//   Sample format: {re[15:0], im[15:0]}, both signed two's complement.
//   Tracks the peak |X|^2 bin while capturing; the testbench or host reads bins through a sync read port.
//   Upstream partner is the FFT core's master stream; this block is the last stage of the chain.
// PARAMETERS
//   NSAMP  32  bins per frame (power of 2)
//   AW     5   address width, log2(NSAMP)
//   DW     32  tdata width, {re,im} 16+16
// PORTS
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state regs (not RAM)
//   s_tvalid   in   1   upstream beat valid
//   s_tready   out  1   sink ready; 1 only in CAPTURE
//   s_tdata    in   32  {re[31:16], im[15:0]}
//   s_tlast    in   1   frame end marker
//   arm        in   1   1-cycle pulse: start a new capture
//   busy       out  1   1 in CAPTURE/FLUSH
//   done       out  1   frame complete; sticky until next arm
//   peak_idx   out  AW  index of the max |X|^2 bin
//   peak_mag   out  32  max re*re+im*im, unsigned
//   frame_err  out  1   tlast framing error (0 when macro absent)
//   rd_addr    in   AW  read address
//   rd_data    out  32  mem[rd_addr], 1-cycle latency
// BEHAVIOUR
//   Reset: state=IDLE, s_tready=0, busy=0, done=0, peak_idx=0, peak_mag=0, frame_err=0, rd_data=0, wr_addr=0; mag pipe valid bits cleared.
//   FSM states: IDLE, CAPTURE, FLUSH, DONE.
//   IDLE/DONE: arm -> CAPTURE at the next edge; same edge clears wr_addr, peak_*, done, frame_err.
//   CAPTURE: s_tready=1, combinational from state only.
//     Handshake = s_tvalid & s_tready: mem[wr_addr]<=s_tdata, wr_addr++.
//     Handshake on wr_addr==NSAMP-1 -> FLUSH; wr_addr wraps to 0.
//     Gaps in s_tvalid stall capture without penalty.
//     arm is ignored in CAPTURE and FLUSH.
//   Magnitude pipe (2 stages):
//     S1 registers re*re, im*im and idx on handshake.
//     S2 registers the sum (32b unsigned; max 0x8000_0000 at re=im=-32768).
//     S2 replaces the peak only if sum > peak_mag, so ties keep the lower index.
//   FLUSH: s_tready=0; lasts 2 cycles while the pipe drains -> DONE.
//   done rises at the 3rd edge after the final handshake edge.
//   peak_* are final whenever done=1.
//   Read port: rd_data<=mem[rd_addr] every cycle, in any state.
//   Read/write same address in the same cycle returns old data.
//   Reset mid-frame: outputs drop asynchronously; RAM keeps partial contents; a new arm is required.
// CONFIGURATION
//   FFT_SINK_TLAST_CHECK_EN defined:
//     tlast on beat k<NSAMP-1: frame_err=1; frame ends early (-> FLUSH); beats k+1..NSAMP-1 keep old RAM data.
//     tlast missing on beat NSAMP-1: frame_err=1; frame completes normally.
//   FFT_SINK_TLAST_CHECK_EN undefined: s_tlast ignored; frame_err tied 0; beat count alone ends the frame.
// STRUCTURE
//   fft_stream_pkg (shared with the source and the FFT core):
//     NSAMP, SAMPLE_W=16, DW, {re,im} field slices, sink state encoding.
//   Sub-module fft_mag2: the 2-stage re^2+im^2 pipe with in-valid/idx passthrough.
//   Top holds the FSM, RAM, peak tracker and read port.
// TESTING
//   1 Arm; 32 beats, tdata={k[15:0],16'h0}, k=0..31, tvalid const 1
//     -> done; peak_idx=31, peak_mag=961; rd_addr=9 gives rd_data=0x0009_0000 next cycle.
//   2 Same frame, tvalid toggling every other cycle
//     -> done only after 32 handshakes; identical RAM/peak.
//   3 All beats 0 except beats 5 and 20 = 0x0003_0004 -> peak_idx=5, peak_mag=25.
//   4 Beat 7=0x8000_8000, rest 0x0001_0001 -> peak_idx=7, peak_mag=0x8000_0000 (no overflow).
//   5 With FFT_SINK_TLAST_CHECK_EN: tlast on beat 10 -> frame_err=1, done, s_tready low after beat 10.
//     Without the macro: the same stimulus requires all 32 beats; frame_err=0.
//   6 reset pulse at beat 12 -> s_tready/busy/done/peak_* =0 immediately;
//     re-arm plus a full frame -> correct result.

Source files
------------

// File: rtl/fft_stream_pkg.sv
// Shared stream definitions for the FFT chain: frame size, sample fields and sink state encoding.
package fft_stream_pkg;

  localparam int NSAMP    = 32;
  localparam int AW       = 5;
  localparam int SAMPLE_W = 16;
  localparam int DW       = 2 * SAMPLE_W;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NSAMP - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } sink_state_e;

  function automatic logic signed [SAMPLE_W-1:0] sample_re(input logic [DW-1:0] d);
    return d[DW-1:SAMPLE_W];
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] sample_im(input logic [DW-1:0] d);
    return d[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/fft_mag2.sv
// Two-stage |X|^2 pipe: stage 1 squares re and im, stage 2 sums them; valid and bin index ride along.
module fft_mag2
  import fft_stream_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_re,
  input  logic signed [SAMPLE_W-1:0] in_im,
  input  logic [AW-1:0]              in_idx,
  output logic                       out_valid,
  output logic [DW-1:0]              out_mag,
  output logic [AW-1:0]              out_idx
);

  logic signed [DW-1:0] re_ext_s, im_ext_s, re_prod_s, im_prod_s;
  logic [DW-1:0]        re_sq_r, im_sq_r, sum_r;
  logic [AW-1:0]        s1_idx_r, s2_idx_r;
  logic                 s1_valid_r, s2_valid_r;

  // Squares of a 16-bit signed value are at most 2^30, so a 32-bit product never wraps.
  assign re_ext_s  = DW'(in_re);
  assign im_ext_s  = DW'(in_im);
  assign re_prod_s = re_ext_s * re_ext_s;
  assign im_prod_s = im_ext_s * im_ext_s;

  // Stage 1: capture the squares on each accepted beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      re_sq_r    <= {DW{1'b0}};
      im_sq_r    <= {DW{1'b0}};
      s1_idx_r   <= {AW{1'b0}};
    end else begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        re_sq_r  <= re_prod_s;
        im_sq_r  <= im_prod_s;
        s1_idx_r <= in_idx;
      end
    end
  end

  // Stage 2: unsigned sum, peaks at 0x8000_0000 for re=im=-32768.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      sum_r      <= {DW{1'b0}};
      s2_idx_r   <= {AW{1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sum_r    <= re_sq_r + im_sq_r;
        s2_idx_r <= s1_idx_r;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_mag   = sum_r;
  assign out_idx   = s2_idx_r;

endmodule

// File: rtl/fft_frame_sink.sv
// AXI-stream frame sink: captures NSAMP bins into RAM, tracks the peak |X|^2 bin, exposes a sync read port.
// Optional macro FFT_SINK_TLAST_CHECK_EN enables tlast framing checks and early frame end.
module fft_frame_sink
  import fft_stream_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tlast,
  input  logic          arm,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] peak_idx,
  output logic [DW-1:0] peak_mag,
  output logic          frame_err,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  sink_state_e   state_r, state_s;
  logic [AW-1:0] wr_addr_r, peak_idx_r, mag_idx_s;
  logic [DW-1:0] peak_mag_r, rd_data_r, mag_s;
  logic [DW-1:0] mem_r [NSAMP];
  logic          flush_cnt_r, done_r;
  logic          hs_s, arm_ok_s, last_beat_s, frame_end_s, mag_valid_s;

  assign s_tready    = (state_r == ST_CAPTURE);
  assign busy        = (state_r == ST_CAPTURE) || (state_r == ST_FLUSH);
  assign hs_s        = s_tvalid && s_tready;
  assign arm_ok_s    = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign last_beat_s = (wr_addr_r == LAST_ADDR);

`ifdef FFT_SINK_TLAST_CHECK_EN
  logic frame_err_r;

  assign frame_end_s = last_beat_s || s_tlast;

  // Flag tlast on any beat but the last, or its absence on the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_r <= 1'b0;
    end else if (arm_ok_s) begin
      frame_err_r <= 1'b0;
    end else if (hs_s && (s_tlast != last_beat_s)) begin
      frame_err_r <= 1'b1;
    end
  end

  assign frame_err = frame_err_r;
`else
  logic tlast_unused_s;

  assign tlast_unused_s = s_tlast;
  assign frame_end_s    = last_beat_s;
  assign frame_err      = 1'b0;
`endif

  // Next-state logic; FLUSH holds two cycles so the magnitude pipe drains before DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (arm) state_s = ST_CAPTURE;
        else     state_s = state_r;
      end
      ST_CAPTURE: begin
        if (hs_s && frame_end_s) state_s = ST_FLUSH;
        else                     state_s = ST_CAPTURE;
      end
      ST_FLUSH: begin
        if (flush_cnt_r) state_s = ST_DONE;
        else             state_s = ST_FLUSH;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, write pointer, flush counter and sticky done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wr_addr_r   <= {AW{1'b0}};
      flush_cnt_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      flush_cnt_r <= (state_r == ST_FLUSH) ? (flush_cnt_r + 1'b1) : 1'b0;
      done_r      <= (state_r == ST_DONE) && !arm;
      if (arm_ok_s)  wr_addr_r <= {AW{1'b0}};
      else if (hs_s) wr_addr_r <= wr_addr_r + AW'(1'b1);
    end
  end

  fft_mag2 u_mag2 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (hs_s),
    .in_re    (sample_re(s_tdata)),
    .in_im    (sample_im(s_tdata)),
    .in_idx   (wr_addr_r),
    .out_valid(mag_valid_s),
    .out_mag  (mag_s),
    .out_idx  (mag_idx_s)
  );

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_idx_r <= {AW{1'b0}};
      peak_mag_r <= {DW{1'b0}};
    end else if (arm_ok_s) begin
      peak_idx_r <= {AW{1'b0}};
      peak_mag_r <= {DW{1'b0}};
    end else if (mag_valid_s && (mag_s > peak_mag_r)) begin
      peak_idx_r <= mag_idx_s;
      peak_mag_r <= mag_s;
    end
  end

  // Capture RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (hs_s) mem_r[wr_addr_r] <= s_tdata;
  end

  // Registered read port; same-address write returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_r <= {DW{1'b0}};
    else       rd_data_r <= mem_r[rd_addr];
  end

  assign done     = done_r;
  assign peak_idx = peak_idx_r;
  assign peak_mag = peak_mag_r;
  assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Self-checking bench for fft_frame_sink: table-driven frames plus hand sequences for corner cases.
module tb_fft_frame_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_tvalid, s_tready, s_tlast, arm, busy, done, frame_err;
  logic [31:0] s_tdata, peak_mag, rd_data;
  logic [4:0]  peak_idx, rd_addr;

  int checks = 0;
  int errors = 0;
  int sent;

`ifdef FFT_SINK_TLAST_CHECK_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif

  typedef struct {
    int          mode;
    bit          gap;
    bit          arm_mid;
    int          tlast_pos;
    logic [4:0]  exp_idx;
    logic [31:0] exp_mag;
    logic        exp_err;
  } vec_t;

  vec_t tbl[5];

  always #5 clk = ~clk;

  fft_frame_sink dut (
    .clk      (clk),
    .reset    (reset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .arm      (arm),
    .busy     (busy),
    .done     (done),
    .peak_idx (peak_idx),
    .peak_mag (peak_mag),
    .frame_err(frame_err),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  function automatic logic [31:0] beat(input int mode, input int k);
    logic [15:0] kk;
    kk = k[15:0];
    case (mode)
      0:       return {kk, 16'h0000};
      1:       return ((k == 5) || (k == 20)) ? 32'h0003_0004 : 32'h0000_0000;
      2:       return (k == 7) ? 32'h8000_8000 : 32'h0001_0001;
      3:       return ((k == 3) || (k == 30)) ? 32'hFFFD_0004 : 32'h0000_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_frame(input int mode, input bit gap, input bit arm_mid, input int tlast_pos,
                            input int k0, input int nbeats, output int n);
    int k;
    int cyc;
    bit hs;
    k   = k0;
    cyc = 0;
    while ((k < nbeats) && (cyc < 400)) begin
      s_tvalid = gap ? (cyc % 2 == 0) : 1'b1;
      s_tdata  = beat(mode, k);
      s_tlast  = (k == tlast_pos);
      arm      = arm_mid && (k == 15);
      hs       = s_tvalid && s_tready;
      tick();
      if (hs) k++;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    arm      = 1'b0;
    n        = k;
  endtask

  // Called right after the edge that accepted the final beat.
  task automatic finish_frame(input string tag);
    chk({tag, "_tready_flush"}, {31'd0, s_tready}, 32'd0);
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_e0"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done_e1"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done_e2"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_e2"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, "_done_e3"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0, 1'b0, 1'b0, 31, 5'd31, 32'd961, 1'b0};
    tbl[1] = '{0, 1'b1, 1'b1, 31, 5'd31, 32'd961, 1'b0};
    tbl[2] = '{1, 1'b0, 1'b0, 31, 5'd5, 32'd25, 1'b0};
    tbl[3] = '{3, 1'b0, 1'b0, -1, 5'd3, 32'd25, TLAST_EN};
    tbl[4] = '{2, 1'b0, 1'b0, 31, 5'd7, 32'h8000_0000, 1'b0};

    reset    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0000_0000;
    s_tlast  = 1'b0;
    arm      = 1'b0;
    rd_addr  = 5'd0;
    tick();
    tick();
    chk("rst_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_peak_idx", {27'd0, peak_idx}, 32'd0);
    chk("rst_peak_mag", peak_mag, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_tready", {31'd0, s_tready}, 32'd0);

    for (int r = 0; r < 5; r++) begin
      do_arm();
      chk($sformatf("r%0d_tready_arm", r), {31'd0, s_tready}, 32'd1);
      chk($sformatf("r%0d_done_clr", r), {31'd0, done}, 32'd0);
      send_frame(tbl[r].mode, tbl[r].gap, tbl[r].arm_mid, tbl[r].tlast_pos, 0, 32, sent);
      chk($sformatf("r%0d_beats", r), sent, 32'd32);
      finish_frame($sformatf("r%0d", r));
      chk($sformatf("r%0d_peak_idx", r), {27'd0, peak_idx}, {27'd0, tbl[r].exp_idx});
      chk($sformatf("r%0d_peak_mag", r), peak_mag, tbl[r].exp_mag);
      chk($sformatf("r%0d_frame_err", r), {31'd0, frame_err}, {31'd0, tbl[r].exp_err});
      for (int a = 0; a < 32; a++) begin
        rd_addr = a[4:0];
        tick();
        chk($sformatf("r%0d_rd%0d", r, a), rd_data, beat(tbl[r].mode, a));
      end
      chk($sformatf("r%0d_done_sticky", r), {31'd0, done}, 32'd1);
    end

    // Read-during-write to address 0, then reset in the middle of a frame.
    do_arm();
    rd_addr  = 5'd0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h0000_0002;
    tick();
    chk("raw_old_data", rd_data, 32'h0001_0001);
    s_tvalid = 1'b0;
    tick();
    chk("raw_new_data", rd_data, 32'h0000_0002);
    for (int k = 1; k < 12; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = beat(0, k);
      tick();
    end
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("mid_peak_idx", {27'd0, peak_idx}, 32'd11);
    chk("mid_peak_mag", peak_mag, 32'd121);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_tready", {31'd0, s_tready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_peak_idx", {27'd0, peak_idx}, 32'd0);
    chk("arst_peak_mag", peak_mag, 32'd0);
    #2;
    reset = 1'b0;
    tick();
    chk("arst_no_restart", {31'd0, s_tready}, 32'd0);
    do_arm();
    send_frame(2, 1'b0, 1'b0, 31, 0, 32, sent);
    chk("rearm_beats", sent, 32'd32);
    finish_frame("rearm");
    chk("rearm_peak_idx", {27'd0, peak_idx}, 32'd7);
    chk("rearm_peak_mag", peak_mag, 32'h8000_0000);
    rd_addr = 5'd0;
    tick();
    chk("rearm_rd0", rd_data, 32'h0001_0001);
    rd_addr = 5'd7;
    tick();
    chk("rearm_rd7", rd_data, 32'h8000_8000);

    // tlast on beat 10.
    do_arm();
    send_frame(0, 1'b0, 1'b0, 10, 0, 11, sent);
    chk("tl_beats_to_10", sent, 32'd11);
`ifdef FFT_SINK_TLAST_CHECK_EN
    finish_frame("tl_early");
    chk("tl_frame_err", {31'd0, frame_err}, 32'd1);
    chk("tl_peak_idx", {27'd0, peak_idx}, 32'd10);
    chk("tl_peak_mag", peak_mag, 32'd100);
    rd_addr = 5'd11;
    tick();
    chk("tl_rd11_old", rd_data, 32'h0001_0001);
    rd_addr = 5'd10;
    tick();
    chk("tl_rd10", rd_data, 32'h000A_0000);
`else
    chk("tl_tready_kept", {31'd0, s_tready}, 32'd1);
    chk("tl_busy_kept", {31'd0, busy}, 32'd1);
    send_frame(0, 1'b0, 1'b0, 10, 11, 32, sent);
    chk("tl_beats_all", sent, 32'd32);
    finish_frame("tl_full");
    chk("tl_frame_err", {31'd0, frame_err}, 32'd0);
    chk("tl_peak_idx", {27'd0, peak_idx}, 32'd31);
    chk("tl_peak_mag", peak_mag, 32'd961);
    rd_addr = 5'd11;
    tick();
    chk("tl_rd11", rd_data, 32'h000B_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
